// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the target and the initiator.
//   DATA_SIZE   : bits per byte on the bus
//   i2c_state_e : target-side protocol states
package i2c_pkg;

  localparam int unsigned DATA_SIZE = 8;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StWaitStop
  } i2c_state_e;

endpackage

// File: rtl/cell_sync.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output
module cell_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a single 7-bit address, no clock stretching.
//   clk      : system clock, all logic on rising edge
//   rst      : synchronous active-high reset
//   sda      : open-drain data line (driven 0 or released)
//   scl      : bus clock from the initiator
//   tx_data  : byte returned on a read, captured at each byte start
//   tx_ld    : one-cycle pulse when tx_data is captured
//   rx_data  : last byte received on a write
//   rx_valid : one-cycle pulse when rx_data updates
//   busy     : high from an address match until STOP or reset
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire                  sda,
  input  logic                 scl,
  input  logic [DATA_SIZE-1:0] tx_data,
  output logic                 tx_ld,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy
);

  localparam logic [2:0] LastBit = 3'(DATA_SIZE - 1);

  logic scl_s, sda_s;
  logic scl_prev_q, sda_prev_q;

  cell_sync u_sync_scl (
    .clk (clk),
    .rst (rst),
    .d   (scl),
    .q   (scl_s)
  );

  cell_sync u_sync_sda (
    .clk (clk),
    .rst (rst),
    .d   (sda),
    .q   (sda_s)
  );

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // Require scl high on both samples so a simultaneous scl/sda change is not a START/STOP.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  i2c_state_e           state_q, state_d;
  logic [DATA_SIZE-1:0] shreg_q, shreg_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 full_q, full_d;     // 8th bit of the current byte has been sampled
  logic                 rw_q, rw_d;
  logic                 ack_q, ack_d;       // initiator's ACK/NACK after a read byte
  logic                 sda_oe_q, sda_oe_d; // 1 pulls sda low
  logic                 busy_q, busy_d;
  logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tx_ld_q, tx_ld_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_q <= 1'b0;
      sda_prev_q <= 1'b0;
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ld_q    <= 1'b0;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ld_q    <= tx_ld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ld_d    = 1'b0;

    if (start_det) begin
      state_d  = StAddr;
      cnt_d    = '0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      cnt_d    = '0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: begin
        end

        StAddr, StWrData: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[DATA_SIZE-2:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            full_d  = (cnt_q == LastBit);
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            if (state_q == StWrData) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = StWrAck;
            end else if (shreg_q[DATA_SIZE-1:1] == ADDR) begin
              rw_d     = shreg_q[0];
              busy_d   = 1'b1;
              sda_oe_d = 1'b1;
              state_d  = StAddrAck;
            end else begin
              state_d = StWaitStop;
            end
          end
        end

        StAddrAck: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              shreg_d  = tx_data;
              tx_ld_d  = 1'b1;
              sda_oe_d = ~tx_data[DATA_SIZE-1];
              state_d  = StRdData;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWrData;
            end
          end
        end

        StWrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StWrData;
          end
        end

        StRdData: begin
          // MSB is already on the bus; each fall presents the next bit, the 8th releases.
          if (scl_fall) begin
            if (cnt_q == LastBit) begin
              cnt_d    = '0;
              sda_oe_d = 1'b0;
              state_d  = StRdAck;
            end else begin
              shreg_d  = {shreg_q[DATA_SIZE-2:0], 1'b0};
              sda_oe_d = ~shreg_q[DATA_SIZE-2];
              cnt_d    = cnt_q + 3'd1;
            end
          end
        end

        StRdAck: begin
          if (scl_rise) begin
            ack_d = sda_s;
          end else if (scl_fall) begin
            if (!ack_q) begin
              shreg_d  = tx_data;
              tx_ld_d  = 1'b1;
              sda_oe_d = ~tx_data[DATA_SIZE-1];
              cnt_d    = '0;
              state_d  = StRdData;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
      endcase
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ld    = tx_ld_q;

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter ADDR, default 7'h42: the 7-bit bus address this target responds to.
REQ-002 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port sda, inout, 1: open-drain data line; driven 0 or released to 1'bz, never driven 1.
REQ-005 SHALL have port scl, input, 1: bus clock from the initiator; no clock stretching.
REQ-006 SHALL have port tx_data, input, 8: byte to return on a read.
REQ-007 SHALL have port tx_ld, output, 1: one-cycle pulse when tx_data is captured.
REQ-008 SHALL have port rx_data, output, 8: last byte received on a write.
REQ-009 SHALL have port rx_valid, output, 1: one-cycle pulse when rx_data updates.
REQ-010 SHALL have port busy, output, 1: high from an address match until STOP or reset.

Function
REQ-011 SHALL pass scl and sda through 2-flop synchronizers; all edge and START/STOP detection SHALL use the synchronized copies.
REQ-012 SHALL detect START as synced sda falling while synced scl is high, and STOP as synced sda rising while synced scl is high.
REQ-013 SHALL sample sda on detected scl rising edges and change its own sda drive only on detected scl falling edges.
REQ-014 SHALL implement the states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-015 SHALL, on START in any state, clear the bit counter, release sda and enter ADDR; this covers repeated START.
REQ-016 SHALL, on STOP in any state, release sda, deassert busy and enter IDLE; a partial byte SHALL be discarded without an rx_valid pulse.
REQ-017 SHALL, in ADDR, shift in 8 bits MSB first; bits [7:1] are the address and bit 0 is R/W (1 = read).
REQ-018 SHALL, at the scl fall after the 8th ADDR bit, on an address match drive sda=0, set busy and enter ADDR_ACK; on a mismatch it SHALL leave sda released and enter WAIT_STOP.
REQ-019 SHALL, at the scl fall ending ADDR_ACK, release sda and enter WR_DATA if R/W=0.
REQ-020 SHALL, at the scl fall ending ADDR_ACK with R/W=1, capture tx_data, pulse tx_ld, drive bit 7 and enter RD_DATA.
REQ-021 SHALL, in WR_DATA, shift in 8 bits.
REQ-022 SHALL, at the scl fall after the 8th WR_DATA bit, update rx_data, pulse rx_valid for exactly one clk, drive sda=0 and enter WR_ACK.
REQ-023 SHALL, at the scl fall ending WR_ACK, release sda and return to WR_DATA; multi-byte writes are ACKed per byte.
REQ-024 SHALL, in RD_DATA, drive bits 6..0 on successive scl falls (0 drives, 1 releases) and release sda at the fall after bit 0, then enter RD_ACK.
REQ-025 SHALL, in RD_ACK, sample sda on the scl rise: 0 (ACK) reloads the shift register as in REQ-020 at the next fall and returns to RD_DATA; 1 (NACK) enters WAIT_STOP.
REQ-026 SHALL, in WAIT_STOP, keep sda released and ignore all bits until START or STOP.
REQ-027 SHALL use a 3-bit bit counter that wraps 7->0 per byte without overflow into adjacent state.
REQ-028 SHALL operate correctly when the scl high and scl low phases are each at least 4 clk cycles.

Reset
REQ-029 SHALL, while rst is high, force state=IDLE, sda=1'bz, rx_data=0, rx_valid=0, tx_ld=0 and busy=0, and clear the shift register, counter and synchronizers.
REQ-030 SHALL, on reset asserted mid-transfer, release sda within one clk and ignore the bus until the next START.

Structure
REQ-031 SHALL place the state encoding and the DATA_SIZE=8 constant in the shared i2c package, common with the initiator.
REQ-032 SHALL reuse the existing cell_sync for the scl and sda synchronizers; no other sub-module.

Verification
REQ-033 SHALL be verified by: initiator writes addr 0x42, R/W=0, data 0xA5 -> sda low on both 9th clocks, rx_data=0xA5, one rx_valid pulse, busy low after STOP.
REQ-034 SHALL be verified by: address 0x43 -> sda released at the ACK slot, no rx_valid, busy never high.
REQ-035 SHALL be verified by: read from 0x42 with tx_data=0x3C, initiator NACKs -> bus bits 0x3C, one tx_ld, WAIT_STOP then IDLE after STOP.
REQ-036 SHALL be verified by: write of 0x11 then 0x22 in one transaction -> two rx_valid pulses with values 0x11 then 0x22, both ACKed.
REQ-037 SHALL be verified by: STOP after 4 data bits -> no rx_valid, IDLE; a following repeated-START read succeeds.
REQ-038 SHALL be verified by: rst pulsed while driving a 0 data bit -> sda=z next clk, all outputs 0.
